// File: rtl/zbus_arbiter.sv
// zbus_arbiter: round-robin arbiter sharing one zbus target port among BN
// initiators. The grant is registered and one-hot; the target-side valid,
// lock and bus are muxed combinationally from the owner, and the target
// acknowledge is routed back to the owner only. A locked owner keeps the
// grant across any number of transfers and idle cycles.
//
// Handshake: a transfer completes in a cycle where zo_vld and zo_ack are
// both high (xfer). zo_vld is the owner's valid gated by the registered
// grant; zo_ack is ignored while nobody owns the port. The owner must hold
// its bus stable while its valid is high and no ack has been seen.
module zbus_arbiter #(
  parameter int BW  = 8,
  parameter int BN  = 4,
  parameter int BNL = $clog2(BN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BN-1:0]    zi_vld,
  input  logic [BN-1:0]    zi_lck,
  input  logic [BW*BN-1:0] zi_bus,
  output logic [BN-1:0]    zi_ack,
  output logic             zo_vld,
  output logic             zo_lck,
  output logic [BW-1:0]    zo_bus,
  input  logic             zo_ack,
  output logic [BN-1:0]    gnt,
  output logic [BNL-1:0]   gnt_idx,
  output logic             busy
);

  // Arbiter state mirrors the grant: IDLE when gnt==0, OWN otherwise.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [BN-1:0]   gnt_q, gnt_d;
  logic [BNL-1:0]  idx_q, idx_d;
  logic [BNL-1:0]  ptr_q, ptr_d;

  logic [BNL-1:0]  own_nxt;
  logic [BNL-1:0]  scan_start;
  logic [BNL-1:0]  scan_idx;
  logic            scan_found;
  int              scan_pos;
  logic            release_own;

  // Target-side mux: OR of the granted slices, zero when nobody owns the port.
  always_comb begin
    zo_bus = '0;
    for (int i = 0; i < BN; i++) begin
      if (gnt_q[i]) begin
        zo_bus = zo_bus | zi_bus[i*BW +: BW];
      end
    end
  end

  assign zo_vld  = |(gnt_q & zi_vld);
  assign zo_lck  = |(gnt_q & zi_lck);
  assign zi_ack  = gnt_q & {BN{zo_ack}};
  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign busy    = |gnt_q;

  // Index following the current owner, wrapping at BN-1.
  always_comb begin
    if (idx_q == BNL'(BN - 1)) begin
      own_nxt = '0;
    end else begin
      own_nxt = idx_q + BNL'(1);
    end
  end

  // Owner gives up the port after an unlocked transfer, or when it is
  // neither requesting nor holding the lock.
  assign release_own = (state_q == ST_OWN) &&
                       ((zo_vld && zo_ack && !zo_lck) || (!zo_vld && !zo_lck));

  // When idle the search starts at the round-robin pointer; on release it
  // starts just after the owner, so the owner itself is examined last and
  // only wins again when nobody else is asking.
  assign scan_start = (state_q == ST_OWN) ? own_nxt : ptr_q;

  // Wrap-around priority search over the live requests.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    scan_pos   = 0;
    for (int k = 0; k < BN; k++) begin
      scan_pos = int'(scan_start) + k;
      if (scan_pos >= BN) begin
        scan_pos = scan_pos - BN;
      end
      if (!scan_found && zi_vld[scan_pos]) begin
        scan_found = 1'b1;
        scan_idx   = BNL'(scan_pos);
      end
    end
  end

  // Next grant, owner index, pointer and state.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_found) begin
          state_d         = ST_OWN;
          gnt_d           = '0;
          gnt_d[scan_idx] = 1'b1;
          idx_d           = scan_idx;
        end
      end
      ST_OWN: begin
        if (release_own) begin
          ptr_d = own_nxt;
          if (scan_found) begin
            gnt_d           = '0;
            gnt_d[scan_idx] = 1'b1;
            idx_d           = scan_idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Registered arbiter state; reset abandons any in-flight transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule
